// File: rtl/multi_shift_unit_pkg.sv
// Shared types for the multi-cycle shift unit:
// shift opcodes, ALU op codes, FSM states.
package multi_shift_unit_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  typedef enum logic [2:0] {
    SH_SRA = 3'b000,
    SH_SRL = 3'b001,
    SH_SLL = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100
  } sh_op_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_ROL  = 4'b1100;
  localparam logic [3:0] ALU_ROR  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic sh_op_valid(
    input logic [2:0] op
  );
    return op <= 3'd4;
  endfunction

  function automatic logic [3:0] alu_op_of(
    input logic [2:0] op
  );
    logic [3:0] r;
    case (op)
      SH_SRA:  r = ALU_SRA;
      SH_SRL:  r = ALU_SRL;
      SH_SLL:  r = ALU_SLL;
      SH_ROL:  r = ALU_ROL;
      SH_ROR:  r = ALU_ROR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; shift/rotate ops move
// operand A by a single bit position.
module alu
  import multi_shift_unit_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] out,
  output logic            zero
);

  always_comb begin
    out = '0;
    case (op)
      ALU_ADD:  out = a + b;
      ALU_SUB:  out = a - b;
      ALU_AND:  out = a & b;
      ALU_OR:   out = a | b;
      ALU_XOR:  out = a ^ b;
      ALU_SLT:
        out = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: out = {31'b0, a < b};
      ALU_NOR:  out = ~(a | b);
      ALU_SRA:  out = {a[31], a[31:1]};
      ALU_SLL:  out = {a[30:0], 1'b0};
      ALU_SRL:  out = {1'b0, a[31:1]};
      ALU_ROL:  out = {a[30:0], a[31]};
      ALU_ROR:  out = {a[0], a[31:1]};
      default:  out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/multi_shift_unit.sv
// Multi-cycle shifter: steps the ALU one bit
// per cycle, Shamt times, then publishes Result.
module multi_shift_unit
  import multi_shift_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] operand,
  input  logic [SHW-1:0]  shamt,
  input  logic [2:0]      sh_op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done,
  output logic            error
);

  state_e state, state_n;

  logic [XLEN-1:0] work;
  logic [SHW-1:0]  count;
  logic [2:0]      op_q;
  logic            accept;
  logic            err_n;

  logic [XLEN-1:0] alu_out;
  logic            alu_zero_unused;

  alu u_alu (
    .a    (work),
    .b    ('0),
    .op   (alu_op_of(op_q)),
    .out  (alu_out),
    .zero (alu_zero_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (sh_op_valid(sh_op)) begin
            accept  = 1'b1;
            state_n = (shamt == '0) ?
                      ST_DONE : ST_SHIFT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (count == SHW'(1)) state_n = ST_DONE;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Start outside IDLE never reaches accept/err_n
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work   <= '0;
      count  <= '0;
      op_q   <= '0;
      result <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      done  <= (state == ST_DONE);
      error <= err_n;
      if (accept) begin
        work  <= operand;
        count <= shamt;
        op_q  <= sh_op;
      end else if (state == ST_SHIFT) begin
        work  <= alu_out;
        count <= count - SHW'(1);
      end
      if (state == ST_DONE) result <= work;
    end
  end

  assign busy = (state == ST_SHIFT) ||
                (state == ST_DONE);
  assign zero = (result == '0);

endmodule

// File: tb/tb_multi_shift_unit.sv
// Directed bench for multi_shift_unit with
// hand-computed results and latencies.
module tb_multi_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic [2:0]  sh_op;
  logic [31:0] result;
  logic        zero, busy, done, error;

  int n_tests = 0;
  int n_fail  = 0;

  multi_shift_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .operand (operand),
    .shamt   (shamt),
    .sh_op   (sh_op),
    .result  (result),
    .zero    (zero),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic run_op(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] opnd,
    input logic [4:0]  sa,
    input logic [31:0] exp,
    input bit          hold
  );
    int lat;
    int busy_n;
    int extra;
    @(posedge clk); #1;
    start = 1'b1; sh_op = op;
    operand = opnd; shamt = sa;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    operand = 32'hDEAD_BEEF;
    shamt   = 5'd7;
    sh_op   = 3'b011;
    lat     = 0;
    busy_n  = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(sa) + 1);
    check({tag, "_busy"}, 32'(busy_n),
          32'(sa) + 1);
    check({tag, "_res"}, result, exp);
    check({tag, "_zero"}, 32'(zero),
          32'(exp == 32'h0));
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check({tag, "_onedone"}, 32'(extra), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0;
    operand = '0; shamt = '0; sh_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", result, 32'h0);
    check("rst_zero", 32'(zero), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    rst = 1'b0;

    run_op("sra4", 3'b000, 32'h8000_0000,
           5'd4, 32'hF800_0000, 1'b0);
    run_op("srl31", 3'b001, 32'h8000_0000,
           5'd31, 32'h0000_0001, 1'b0);
    run_op("sll0", 3'b010, 32'h0000_0001,
           5'd0, 32'h0000_0001, 1'b0);
    run_op("sll1", 3'b010, 32'h8000_0000,
           5'd1, 32'h0000_0000, 1'b0);
    run_op("ror1", 3'b100, 32'h0000_0001,
           5'd1, 32'h8000_0000, 1'b0);
    run_op("rol4", 3'b011, 32'h8000_0001,
           5'd4, 32'h0000_0018, 1'b0);

    @(posedge clk); #1;
    start = 1'b1; sh_op = 3'b111;
    operand = 32'h1234_5678; shamt = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("inv_err", 32'(error), 1);
    check("inv_busy", 32'(busy), 0);
    check("inv_res", result, 32'h0000_0018);
    @(posedge clk); #1;
    check("inv_err_off", 32'(error), 0);
    check("inv_busy2", 32'(busy), 0);

    run_op("hold", 3'b001, 32'h0000_FF00,
           5'd3, 32'h0000_1FE0, 1'b1);
    check("hold_err", 32'(error), 0);

    @(posedge clk); #1;
    start = 1'b1; sh_op = 3'b010;
    operand = 32'h0000_000F; shamt = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_res", result, 32'h0);
    check("arst_zero", 32'(zero), 1);
    check("arst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b1; sh_op = 3'b010;
    operand = 32'h0000_000F; shamt = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("post_busy", 32'(busy), 1);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        check("post_res", result, 32'h3C);
      end
    end
    check("post_dones", 32'(dones), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_shift_unit.md
MULTI_SHIFT_UNIT -- requirements
Module: multi_shift_unit

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Start  input  1  request pulse; sampled only in IDLE.
REQ-004 Operand  input  32  value to shift; captured on accepted Start.
REQ-005 Shamt  input  5  shift amount 0..31; captured on accepted Start.
REQ-006 ShOp  input  3  000 SRA, 001 SRL, 010 SLL, 011 ROL, 100 ROR; 101..111 invalid.
REQ-007 Result  output  32  registered shift result; held until next Done.
REQ-008 Zero  output  1  high when Result == 0.
REQ-009 Busy  output  1  high in SHIFT and DONE states.
REQ-010 Done  output  1  one-cycle pulse; Result is valid in the same cycle.
REQ-011 Error  output  1  one-cycle pulse on Start with invalid ShOp.

Function
REQ-012 The block SHALL run a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE, Start with a valid ShOp and Shamt != 0 SHALL load Work=Operand, Count=Shamt, latch ShOp, and go to SHIFT.
REQ-014 In IDLE, Start with a valid ShOp and Shamt == 0 SHALL load Work=Operand and go directly to DONE.
REQ-015 In IDLE, Start with invalid ShOp SHALL stay in IDLE, leave Result unchanged, and pulse Error for the next cycle.
REQ-016 Each SHIFT cycle SHALL drive the ALU with A=Work, B=0, and Op mapped from the latched ShOp: SRA->1000, SRL->1010, SLL->1001, ROL->1100, ROR->1101.
REQ-017 Each SHIFT cycle SHALL perform Work<=ALU Out and Count<=Count-1; when Count==1, next state SHALL be DONE.
REQ-018 In DONE, Result<=Work SHALL update and Done SHALL be high for exactly one cycle; next state SHALL be IDLE.
REQ-019 Latency from the Start edge to Done high SHALL be Shamt+1 cycles; throughput SHALL be one operation per Shamt+2 cycles.
REQ-020 Start in SHIFT or DONE SHALL be ignored without being queued, and SHALL NOT raise Error.
REQ-021 Operand, Shamt and ShOp changes after acceptance SHALL NOT affect the operation in flight.
REQ-022 Zero SHALL be derived from the Result register, not from the ALU Zero output.
REQ-023 Busy SHALL be combinational from state; Done and Error SHALL be registered.

Reset
REQ-024 Reset SHALL asynchronously force state IDLE, Work=0, Count=0, Result=0, Done=0, Error=0.
REQ-025 Because Result resets to 0, Zero SHALL be 1 out of reset and Busy SHALL be 0.
REQ-026 Reset mid-operation SHALL abort the operation; no Done SHALL follow it.
REQ-027 After Reset deasserts, the first rising edge SHALL be able to accept Start.

Structure
REQ-028 A shared package SHALL hold the ShOp encodings, the ALU Op codes (1000/1010/1001/1100/1101) and the state enumeration.
REQ-029 The block SHALL instantiate the existing alu module as its single sub-module; it SHALL NOT re-implement shift logic.
REQ-030 The mapping from ShOp to ALU Op SHALL be one combinational function defined in the package.

Verification
REQ-031 SRA: Operand 0x80000000, Shamt 4 -> Done 5 cycles after Start; Result 0xF8000000; Zero 0.
REQ-032 SRL: Operand 0x80000000, Shamt 31 -> Done 32 cycles after Start; Result 0x00000001; Busy high for 32 cycles.
REQ-033 SLL: Operand 0x00000001, Shamt 0 -> Done 1 cycle after Start; Result 0x00000001. Then SLL 0x80000000 by 1 -> Result 0x0 and Zero 1.
REQ-034 ROR: Operand 0x00000001, Shamt 1 -> Result 0x80000000. ROL: Operand 0x80000001, Shamt 4 -> Result 0x00000018.
REQ-035 Start with ShOp 111 -> Error pulses for 1 cycle, Busy stays 0, Result unchanged. Start asserted during SHIFT -> ignored, with a single Done.
REQ-036 Reset asserted 3 cycles into SHL 0xF by 10 -> immediate IDLE, Result 0, Zero 1, no Done; a new Start is accepted next edge after release.
